fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port (wr_cs/wr_en/data_in) between NREQ producers.
- Holds a local credit counter mirroring FIFO occupancy, so writes are registered and the FIFO can never overflow.
- Supports locked bursts: a granted producer keeps the port until it marks its last beat or hits MAX_BURST.
- Sits directly in front of the team's sync FIFO; consumers read that FIFO unchanged.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DWIDTH, 8, data width; matches the FIFO's DWIDTH
- AWIDTH, 8, FIFO address width; usable capacity CAP = (1<<AWIDTH)-1 entries (FIFO asserts full at DEPTH-1)
- MAX_BURST, 4, maximum beats per locked grant (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req  in  NREQ  per-requester valid
- req_last  in  NREQ  beat is last of burst
- req_data  in  NREQ*DWIDTH  packed data, requester i at [i*DWIDTH +: DWIDTH]
- ack  out  NREQ  one-hot, combinational; beat of requester i accepted this cycle
- fifo_wr_cs  out  1  registered, to FIFO wr_cs
- fifo_wr_en  out  1  registered, to FIFO wr_en
- fifo_data  out  DWIDTH  registered, to FIFO data_in
- fifo_pop  in  1  FIFO read accepted this cycle (rd_cs & rd_en & !empty)
- grant_id  out  clog2(NREQ)  current/last owner
- busy  out  1  high in LOCK state
- credits  out  AWIDTH  free entries remaining
- err_pop  out  1  sticky; pop seen while credits==CAP

Behaviour:
- Reset (rst==0 at posedge): state IDLE; credits=CAP; fifo_wr_cs=fifo_wr_en=0; fifo_data=0; grant_id=NREQ-1 (so requester 0 wins first); beat count=0; err_pop=0. ack is 0 while rst==0.
- Accept condition: at most one ack bit per cycle, and only when credits>0.
- IDLE:
  - if credits>0 and |req, pick the first requester with req set, searching from grant_id+1 with wrap modulo NREQ.
  - ack that requester, set grant_id to it, beat count=1.
  - if !req_last[winner] and MAX_BURST>1, go to LOCK; else stay IDLE.
- LOCK (owner = grant_id):
  - only the owner may be acked, and only when req[owner] && credits>0; other requesters are ignored.
  - on an accepted beat, beat count+1. Return to IDLE when the beat has req_last, or when beat count reaches MAX_BURST.
  - if req[owner]==0 for a cycle, release immediately to IDLE with no ack that cycle (no bubble-hold). Arbitration resumes next cycle.
  - credits==0 does not release the lock; wait.
- Write path: any ack asserted -> next cycle fifo_wr_cs=fifo_wr_en=1 and fifo_data=req_data of the acked requester. Otherwise both enables are 0 and fifo_data holds its value. Latency ack->FIFO write is 1 cycle.
- Credits, updated every cycle:
  - push (ack) only: -1.
  - pop only: +1.
  - push and pop together: unchanged.
  - pop with credits==CAP: no change, set err_pop.
  - credits never wraps below 0, because ack is gated by credits>0.
- Fairness: after a grant completes, the granted requester has lowest priority next arbitration. Bound: no requester waits more than (NREQ-1)*MAX_BURST accepted beats plus credit stalls.
- Reset mid-burst: the lock is dropped, the in-flight registered write is squashed (enables 0), and credits return to CAP. The FIFO must be reset in the same cycle.

Decomposition:
- Shared package fifo_ctrl_pkg holds the state encoding (ST_IDLE, ST_LOCK), the clog2 helper and the CAP derivation, so the FIFO and future read-side controllers use the same ones.
- One sub-module: rr_pick, a combinational round-robin priority picker. Inputs are req vector and last grant index; outputs are one-hot winner and index. It is reused by a planned read-side scheduler.

Test Plan:
- Setup for all scenarios: NREQ=4, DWIDTH=8, AWIDTH=3 (CAP=7), MAX_BURST=4.
- Reset then req=4'b1111, all req_last=1, data i=8'h10+i -> acks cycle 0,1,2,3 to req 0,1,2,3. FIFO sees 10,11,12,13 one cycle later. credits goes 7->3.
- Burst lock: req0 holds 6 beats with req_last=0, req1 constantly requesting -> req0 gets 4 beats, then req1 acked, then req0 resumes. busy high during req0 beats 2-4.
- Full stop: no pops, req2 streams -> exactly 7 acks. credits=0 and ack=0 thereafter. One fifo_pop -> one more ack next cycle, credits back to 0.
- Simultaneous push+pop at credits=3 for 5 cycles -> credits stays 3 and 5 writes are issued.
- Owner drops req in LOCK after beat 2 -> next cycle IDLE; req3 acked in the following arbitration; no stray fifo_wr_en.
- Reset (rst=0) mid-burst with a write pending -> next cycle fifo_wr_en=0, credits=7, busy=0. A pop at credits=7 sets err_pop=1, which stays set until reset.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO control blocks.
// Holds the arbiter state encoding, a clog2 helper usable in parameter
// port lists, and the derivation of usable FIFO capacity from the
// address width. The sync FIFO asserts full at DEPTH-1, so the usable
// capacity is one entry less than the address space.
package fifo_ctrl_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Minimum bit count to index 'value' items; never returns less than 1
    // so that index ports always have a legal width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // Usable entries of a sync FIFO with the given address width.
    function automatic int fifo_cap(input int awidth);
        return (1 << awidth) - 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Searches the request vector starting one position after the last
// grant, wrapping modulo NREQ, and reports the first requester found.
// Ports:
//   req        in   NREQ  request vector
//   last       in   IW    index of the previous grant
//   winner     out  NREQ  one-hot winner (all zero when nothing requests)
//   winner_idx out  IW    index of the winner (equals last when none)
//   found      out  1     at least one request was present
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   winner_idx,
    output logic            found
);

    logic [IW-1:0] cand;

    always_comb begin
        winner     = '0;
        winner_idx = last;
        found      = 1'b0;
        cand       = '0;
        // Offset 1 first so the previous owner is considered last.
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (!found && req[cand]) begin
                found      = 1'b1;
                winner_idx = cand;
            end
        end
        if (found) winner[winner_idx] = 1'b1;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one sync FIFO write port between
// NREQ producers, with locked bursts and a credit counter that mirrors
// FIFO occupancy so the FIFO can never be overfilled.
// Handshake: a producer presents req[i] with req_data/req_last; a beat is
// transferred in the cycle ack[i] is high. ack is combinational, one-hot,
// and only asserted while credits > 0 and rst is released. The beat is
// written to the FIFO one cycle later through the registered write port.
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   req, req_last   per-requester valid and last-beat flags
//   req_data        packed data, requester i at [i*DWIDTH +: DWIDTH]
//   ack             one-hot beat acceptance
//   fifo_wr_cs/en   registered FIFO write strobes
//   fifo_data       registered FIFO write data (holds when idle)
//   fifo_pop        FIFO read accepted this cycle
//   grant_id        current or most recent owner
//   busy            high while a burst lock is held
//   credits         free FIFO entries remaining
//   err_pop         sticky: pop observed while the FIFO was empty
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter  int NREQ      = 4,
    parameter  int DWIDTH    = 8,
    parameter  int AWIDTH    = 8,
    parameter  int MAX_BURST = 4,
    localparam int IW        = clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_last,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   fifo_wr_cs,
    output logic                   fifo_wr_en,
    output logic [DWIDTH-1:0]      fifo_data,
    input  logic                   fifo_pop,
    output logic [IW-1:0]          grant_id,
    output logic                   busy,
    output logic [AWIDTH-1:0]      credits,
    output logic                   err_pop
);

    localparam logic [AWIDTH-1:0] CAP       = AWIDTH'(fifo_cap(AWIDTH));
    localparam int                BW        = clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]     BURST_MAX = BW'(MAX_BURST);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [AWIDTH-1:0] credits_q;
    logic              wr_q;
    logic [DWIDTH-1:0] data_q;
    logic              err_q;

    logic [NREQ-1:0]   pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_found;
    logic [IW-1:0]     win_idx;
    logic              has_credit;
    logic              push;
    logic              pop_ok;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (req),
        .last       (grant_q),
        .winner     (pick_onehot),
        .winner_idx (pick_idx),
        .found      (pick_found)
    );

    assign has_credit = (credits_q != '0);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        ack     = '0;
        win_idx = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (has_credit && pick_found) begin
                    ack     = pick_onehot;
                    win_idx = pick_idx;
                    grant_d = pick_idx;
                    beat_d  = BW'(1);
                    if (!req_last[pick_idx] && (MAX_BURST > 1)) state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                // Owner dropping its request ends the burst at once; a
                // credit stall alone keeps the lock held.
                if (!req[grant_q]) begin
                    state_d = ST_IDLE;
                end else if (has_credit) begin
                    ack[grant_q] = 1'b1;
                    beat_d       = beat_q + BW'(1);
                    if (req_last[grant_q] || (beat_q + BW'(1) >= BURST_MAX)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rst) ack = '0;
    end

    assign push = |ack;
    // A pop when all entries are free cannot be real, so it never adds a credit.
    assign pop_ok = fifo_pop && (credits_q != CAP);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= IW'(NREQ - 1);
            beat_q    <= '0;
            credits_q <= CAP;
            wr_q      <= 1'b0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            wr_q    <= push;
            if (push) data_q <= req_data[win_idx*DWIDTH +: DWIDTH];
            case ({push, pop_ok})
                2'b10:   credits_q <= credits_q - AWIDTH'(1);
                2'b01:   credits_q <= credits_q + AWIDTH'(1);
                default: credits_q <= credits_q;
            endcase
            if (fifo_pop && (credits_q == CAP)) err_q <= 1'b1;
        end
    end

    assign fifo_wr_cs = wr_q;
    assign fifo_wr_en = wr_q;
    assign fifo_data  = data_q;
    assign grant_id   = grant_q;
    assign busy       = (state_q == ST_LOCK);
    assign credits    = credits_q;
    assign err_pop    = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NREQ = 4;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 3;
  localparam int MAX_BURST = 4;
  localparam int CAP = 7;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req = '0;
  logic [NREQ-1:0]        req_last = '0;
  logic [NREQ*DWIDTH-1:0] req_data = '0;
  logic                   fifo_pop = 1'b0;
  logic [NREQ-1:0]        ack;
  logic                   fifo_wr_cs, fifo_wr_en;
  logic [DWIDTH-1:0]      fifo_data;
  logic [1:0]             grant_id;
  logic                   busy;
  logic [AWIDTH-1:0]      credits;
  logic                   err_pop;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .ack(ack), .fifo_wr_cs(fifo_wr_cs), .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .grant_id(grant_id), .busy(busy), .credits(credits), .err_pop(err_pop)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard / behavioural model
  logic [DWIDTH-1:0] exp_q[$];
  int m_cred = CAP;
  int m_owner = -1;        // locked owner, -1 when arbitration is open
  int m_last = NREQ - 1;   // last granted requester
  int m_beats = 0;
  bit m_wr = 1'b0;
  logic [DWIDTH-1:0] m_data = '0;
  bit m_err = 1'b0;

  always @(negedge clk) begin : model
    int win;
    logic [NREQ-1:0] exp_ack;
    if (model_on) begin
      win = -1;
      if (rst) begin
        if (m_owner >= 0) begin
          if (req[m_owner] && m_cred > 0) win = m_owner;
        end else if (m_cred > 0) begin
          for (int k = 1; k <= NREQ; k++)
            if (win < 0 && req[(m_last + k) % NREQ]) win = (m_last + k) % NREQ;
        end
      end
      exp_ack = '0;
      if (win >= 0) exp_ack[win] = 1'b1;
      chk("m_ack", ack, exp_ack);
      chk("m_busy", busy, m_owner >= 0);
      chk("m_grant", grant_id, m_last);
      chk("m_credits", credits, m_cred);
      chk("m_wr_en", fifo_wr_en, m_wr);
      chk("m_wr_cs", fifo_wr_cs, m_wr);
      chk("m_data", fifo_data, m_data);
      chk("m_err", err_pop, m_err);
      if (fifo_wr_en === 1'b1) begin
        if (exp_q.size() == 0) chk("sb_unexpected_write", 1, 0);
        else chk("sb_data", fifo_data, exp_q.pop_front());
      end
      // advance model by one clock
      if (!rst) begin
        m_cred = CAP; m_owner = -1; m_last = NREQ - 1; m_beats = 0;
        m_wr = 1'b0; m_data = '0; m_err = 1'b0; exp_q.delete();
      end else begin
        m_wr = (win >= 0);
        if (win >= 0) begin
          m_data = req_data[win*DWIDTH +: DWIDTH];
          exp_q.push_back(m_data);
        end
        if (m_owner >= 0) begin
          if (!req[m_owner]) m_owner = -1;
          else if (win >= 0) begin
            m_beats++;
            if (req_last[m_owner] || m_beats == MAX_BURST) m_owner = -1;
          end
        end else if (win >= 0) begin
          m_last = win;
          m_beats = 1;
          if (!req_last[win] && MAX_BURST > 1) m_owner = win;
        end
        if (fifo_pop && m_cred == CAP) begin
          m_err = 1'b1;
          if (win >= 0) m_cred--;
        end else begin
          m_cred = m_cred + (fifo_pop ? 1 : 0) - ((win >= 0) ? 1 : 0);
        end
      end
    end
  end

  // driver tasks
  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_n(input int n);
    req = '0;
    fifo_pop = 1'b1;
    repeat (n) begin to_neg(); to_next(); end
    fifo_pop = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n_ack;
    int n_wr;
    logic [NREQ-1:0] s2_ack[7];
    bit s2_busy[7];
    s2_ack = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
    s2_busy = '{0, 1, 1, 1, 0, 0, 1};

    // reset
    rst = 1'b0;
    to_next();
    model_on = 1'b1;
    to_neg();
    chk("rst_credits", credits, 7);
    chk("rst_grant", grant_id, 3);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err_pop, 0);
    to_next();
    rst = 1'b1;

    // scenario 1: all request single beats, round-robin 0..3
    req = 4'b1111; req_last = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[i*8 +: 8] = 8'h10 + i;
    for (int i = 0; i < 4; i++) begin
      to_neg();
      chk("s1_ack", ack, 4'b0001 << i);
      chk("s1_credits", credits, 7 - i);
      if (i > 0) chk("s1_data", fifo_data, 8'h10 + i - 1);
      to_next();
    end
    req = '0;
    to_neg();
    chk("s1_last_data", fifo_data, 8'h13);
    chk("s1_credits_end", credits, 3);
    to_next();
    pop_n(4);

    // scenario 2: burst lock of req0 against a waiting req1
    req = 4'b0011; req_last = 4'b0010;
    req_data[15:8] = 8'hB1;
    for (int i = 0; i < 7; i++) begin
      req_data[7:0] = 8'hA0 + i;
      to_neg();
      chk("s2_ack", ack, s2_ack[i]);
      chk("s2_busy", busy, s2_busy[i]);
      to_next();
    end
    req = '0; req_last = '0;
    to_neg();
    chk("s2_credits", credits, 0);
    chk("s2_grant", grant_id, 0);
    chk("s2_data", fifo_data, 8'hA6);
    to_next();
    pop_n(7);

    // scenario 3: full stop with no pops
    req = 4'b0100; req_last = 4'b1111;
    n_ack = 0;
    for (int i = 0; i < 10; i++) begin
      req_data[23:16] = 8'hC0 + i;
      to_neg();
      if (ack[2] === 1'b1) n_ack++;
      to_next();
    end
    fifo_pop = 1'b1;
    to_neg();
    chk("s3_ack_count", n_ack, 7);
    chk("s3_credits_zero", credits, 0);
    chk("s3_ack_stalled", ack, 0);
    to_next();
    fifo_pop = 1'b0;
    to_neg();
    chk("s3_ack_after_pop", ack, 4'b0100);
    chk("s3_credits_one", credits, 1);
    to_next();
    req = '0;
    to_neg();
    chk("s3_credits_back", credits, 0);
    to_next();

    // scenario 4: push and pop together at credits 3
    pop_n(3);
    req = 4'b0100; fifo_pop = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 5; i++) begin
      req_data[23:16] = 8'h40 + i;
      to_neg();
      chk("s4_ack", ack, 4'b0100);
      chk("s4_credits", credits, 3);
      if (fifo_wr_en === 1'b1) n_wr++;
      to_next();
    end
    req = '0; fifo_pop = 1'b0;
    to_neg();
    if (fifo_wr_en === 1'b1) n_wr++;
    chk("s4_writes", n_wr, 5);
    chk("s4_credits_end", credits, 3);
    to_next();

    // scenario 5: owner drops request inside a lock
    req = 4'b0001; req_last = 4'b0000; req_data[7:0] = 8'h77;
    to_neg(); chk("s5_beat1", ack, 4'b0001); chk("s5_busy1", busy, 0); to_next();
    to_neg(); chk("s5_beat2", ack, 4'b0001); chk("s5_busy2", busy, 1); to_next();
    req = 4'b1000; req_last = 4'b1000; req_data[31:24] = 8'h33;
    to_neg(); chk("s5_drop_ack", ack, 0); chk("s5_drop_busy", busy, 1); to_next();
    to_neg(); chk("s5_req3_ack", ack, 4'b1000); chk("s5_no_stray", fifo_wr_en, 0); to_next();
    req = '0;
    to_neg(); chk("s5_grant3", grant_id, 3); chk("s5_data", fifo_data, 8'h33); to_next();

    // scenario 6: reset mid-burst, then pop while empty
    pop_n(2);
    req = 4'b0010; req_last = 4'b0000; req_data[15:8] = 8'h5A;
    to_neg(); chk("s6_ack", ack, 4'b0010); to_next();
    rst = 1'b0;
    to_neg(); chk("s6_ack_in_rst", ack, 0); chk("s6_pending", fifo_wr_en, 1); to_next();
    rst = 1'b1; req = '0;
    to_neg();
    chk("s6_squash", fifo_wr_en, 0);
    chk("s6_credits", credits, 7);
    chk("s6_busy", busy, 0);
    to_next();
    fifo_pop = 1'b1;
    to_neg(); chk("s6_err_before", err_pop, 0); to_next();
    fifo_pop = 1'b0;
    repeat (3) begin
      to_neg(); chk("s6_err_sticky", err_pop, 1); chk("s6_credits_cap", credits, 7); to_next();
    end
    rst = 1'b0;
    to_neg(); to_next();
    rst = 1'b1;
    to_neg(); chk("s6_err_cleared", err_pop, 0); to_next();

    model_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
